vga_plot_arbiter: RTL and testbench
===================================

// Module: vga_plot_arbiter
// PURPOSE
//  Sits directly downstream of the sprite drawers (gator open/close, pellets, score) and upstream of vga_adapter.
//  Merges N independent pixel-plot streams into the adapter's single x/y/colour/plot port.
//  Grants are round-robin, with a request/grant/done handshake, and a client holds the port for a whole sprite.
//  A built-in clear engine fills the whole screen with CLEAR_COLOUR on request.
// PARAMETERS
//  N_CLIENTS     2       number of drawer clients (2..4)
//  X_W           8       x coordinate width
//  Y_W           7       y coordinate width
//  COLOUR_W      3       colour width (1 bit/channel, RGB)
//  SCREEN_W      160     clear-sweep width in pixels
//  SCREEN_H      120     clear-sweep height in pixels
//  CLEAR_COLOUR  3'b000  colour written by the clear engine
// PORTS
//  CLOCK_50    in   1              system clock, 50 MHz
//  resetn      in   1              asynchronous, active-low reset
//  req         in   N_CLIENTS      client i requests the port; held high until done
//  done        in   N_CLIENTS      client i has finished its sprite; 1-cycle pulse while granted
//  gnt         out  N_CLIENTS      one-hot grant, registered
//  x_in        in   N_CLIENTS*X_W  packed client x; client i at [i*X_W +: X_W]
//  y_in        in   N_CLIENTS*Y_W  packed client y
//  colour_in   in   N_CLIENTS*COLOUR_W  packed client colour
//  plot_in     in   N_CLIENTS      client plot strobes
//  clear_req   in   1              pulse: request a full-screen clear
//  clear_busy  out  1              high from clear acceptance until the last clear pixel is issued
//  x           out  X_W            to vga_adapter.x
//  y           out  Y_W            to vga_adapter.y
//  colour      out  COLOUR_W       to vga_adapter.colour
//  plot        out  1              to vga_adapter.plot
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - gnt=0, plot=0, x=0, y=0, colour=0, clear_busy=0.
//   - State is IDLE, the round-robin pointer is 0, and clear_pending is 0.
//  FSM states: IDLE, CLEAR, GRANT.
//   IDLE:
//    - If clear_pending is set, go to CLEAR.
//    - Otherwise, if any req is set, grant the first requester at or after the pointer (cyclic search), then go to GRANT.
//    - gnt asserts in the cycle after the grant decision.
//   GRANT:
//    - Only the granted client's plot_in/x_in/y_in/colour_in pass through, registered.
//    - plot(t+1) = plot_in[g](t) && gnt[g](t). The path has 1-cycle latency.
//    - Exit when done[g]=1 or req[g]=0:
//      - gnt clears the next cycle and the state returns to IDLE.
//      - The pointer becomes g+1 (mod N_CLIENTS).
//    - A plot_in[g] in the same cycle as done[g] is still issued.
//    - Plot strobes from clients without a grant are ignored; there is no buffering.
//   CLEAR:
//    - Row-major sweep: x=0..SCREEN_W-1 inner, y=0..SCREEN_H-1 outer.
//    - plot=1 and colour=CLEAR_COLOUR every cycle, i.e. SCREEN_W*SCREEN_H cycles (19200 by default).
//    - After (SCREEN_W-1, SCREEN_H-1) is issued, return to IDLE: counters reset and clear_busy drops the same cycle plot drops.
//  clear_req handling:
//   - clear_req sets clear_pending in any state.
//   - A clear requested during GRANT is deferred until the current grant is released; the client is never pre-empted.
//   - clear_req during CLEAR is ignored; it does not restart the sweep.
//   - clear_busy is high from the cycle after clear_req until the sweep ends.
//  Priority in IDLE: a pending clear beats every client. Clients are round-robin among themselves, so none starves.
//  Width rules:
//   - x/y counters are X_W/Y_W bits and compare against SCREEN_W-1/SCREEN_H-1.
//   - There is no wrap beyond screen bounds.
//   - Client coordinates pass through unmodified.
//  IDLE outputs: plot=0. x/y/colour hold their last values.
//  Reset mid-sweep or mid-grant: everything returns to reset values immediately and the pending clear is lost.
// STRUCTURE
//  Shared package (plot_pkg):
//   - FSM state encoding (one-hot, 3 bits).
//   - Default screen constants (SCREEN_W=160, SCREEN_H=120).
//   - Colour width constant and colour constants.
//  Sub-module rr_arbiter:
//   - Inputs: req and pointer.
//   - Output: one-hot grant.
//   - Purely combinational, instantiated once.
//  All other logic, including the FSM, the clear counters and the output registers, stays in this module.
// TESTING
//  T1 reset: resetn=0 mid-CLEAR at x=37,y=5 -> gnt=0, plot=0, x=0, y=0, clear_busy=0 at once; after release the state is IDLE.
//  T2 single client: req[0]=1, then 30 plot_in pulses at x=30..59, y=30 -> plot echoes each pulse 1 cycle later with the same x/y/colour; done[0] -> gnt=0 next cycle.
//  T3 round-robin: req=2'b11 held, each client pulses done after 4 plots -> grants alternate 01,10,01,10; no client receives two consecutive grants.
//  T4 clear: clear_req pulse in IDLE -> exactly 19200 plot cycles with colour=0; the last pixel is (159,119); clear_busy falls the same cycle plot falls.
//  T5 deferred clear: clear_req while client 1 is granted -> client 1 finishes all plots uninterrupted; the sweep starts after done[1]; req[0] is waiting but is not granted until the sweep ends.
//  T6 ungranted strobe: plot_in[1]=1 while gnt=01 -> no plot is issued for client 1's coordinates.

Source files
------------

// File: rtl/vga_plot_arbiter_pkg.sv
// Shared definitions for the VGA plot arbiter: FSM encoding, default
// screen geometry, colour constants and the round-robin pointer helper.
package vga_plot_arbiter_pkg;

    // One-hot FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_CLEAR = 3'b010,
        ST_GRANT = 3'b100
    } arb_state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W_DEF = 3;

    localparam logic [COLOUR_W_DEF-1:0] COLOUR_BLACK = 3'b000;

    // Next round-robin start position after client g releases the port
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Drawer-side bus: request/grant/done handshake plus packed pixel streams.
interface vga_plot_arbiter_if #(
    parameter int N_CLIENTS = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3
);
    logic [N_CLIENTS-1:0]          req;
    logic [N_CLIENTS-1:0]          done;
    logic [N_CLIENTS-1:0]          gnt;
    logic [N_CLIENTS*X_W-1:0]      x_in;
    logic [N_CLIENTS*Y_W-1:0]      y_in;
    logic [N_CLIENTS*COLOUR_W-1:0] colour_in;
    logic [N_CLIENTS-1:0]          plot_in;

    // Drawers
    modport master (
        output req, done, x_in, y_in, colour_in, plot_in,
        input  gnt
    );

    // Arbiter
    modport slave (
        input  req, done, x_in, y_in, colour_in, plot_in,
        output gnt
    );
endinterface

// File: rtl/vga_plot_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// searching cyclically. Returns a one-hot grant (all zero if no request).
module rr_arbiter #(
    parameter int N_CLIENTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [N_CLIENTS-1:0] gnt
);

    // Cyclic priority search starting at ptr
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            idx = (int'(ptr) + i) % N_CLIENTS;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Merges N sprite-drawer pixel streams onto the single vga_adapter plot
// port. Clients are granted round-robin and keep the port for a whole
// sprite; a built-in clear engine sweeps the screen with CLEAR_COLOUR.
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int                  N_CLIENTS    = 2,
    parameter int                  X_W          = 8,
    parameter int                  Y_W          = 7,
    parameter int                  COLOUR_W     = COLOUR_W_DEF,
    parameter int                  SCREEN_W     = SCREEN_W_DEF,
    parameter int                  SCREEN_H     = SCREEN_H_DEF,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = COLOUR_BLACK
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    vga_plot_arbiter_if.slave   bus,
    input  logic                clear_req,
    output logic                clear_busy,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam int PTR_W = (N_CLIENTS > 2) ? 2 : 1;

    arb_state_t           state, state_nxt;
    logic [PTR_W-1:0]     ptr;
    logic [N_CLIENTS-1:0] arb_gnt;
    logic                 clear_pending;
    logic [X_W-1:0]       cx;
    logic [Y_W-1:0]       cy;
    logic                 last_px;

    // Fields of the currently granted client
    logic [PTR_W-1:0]     g_idx;
    logic                 g_req, g_done, g_plot;
    logic [X_W-1:0]       g_x;
    logic [Y_W-1:0]       g_y;
    logic [COLOUR_W-1:0]  g_colour;
    logic                 g_release;

    rr_arbiter #(
        .N_CLIENTS (N_CLIENTS),
        .PTR_W     (PTR_W)
    ) u_rr (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    assign last_px   = (cx == X_W'(SCREEN_W - 1)) && (cy == Y_W'(SCREEN_H - 1));
    assign g_release = g_done || !g_req;

    // Select the granted client's signals; gnt is one-hot or zero
    always_comb begin
        g_idx    = '0;
        g_req    = 1'b0;
        g_done   = 1'b0;
        g_plot   = 1'b0;
        g_x      = '0;
        g_y      = '0;
        g_colour = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (bus.gnt[i]) begin
                g_idx    = PTR_W'(i);
                g_req    = bus.req[i];
                g_done   = bus.done[i];
                g_plot   = bus.plot_in[i];
                g_x      = bus.x_in[i*X_W +: X_W];
                g_y      = bus.y_in[i*Y_W +: Y_W];
                g_colour = bus.colour_in[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // Next-state logic: a pending clear outranks every client in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clear_pending)
                    state_nxt = ST_CLEAR;
                else if (|bus.req)
                    state_nxt = ST_GRANT;
            end
            ST_GRANT: if (g_release) state_nxt = ST_IDLE;
            ST_CLEAR: if (last_px)   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control state: FSM, grant, pointer, clear bookkeeping and sweep counters
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            bus.gnt       <= '0;
            ptr           <= '0;
            clear_pending <= 1'b0;
            clear_busy    <= 1'b0;
            cx            <= '0;
            cy            <= '0;
        end else begin
            state <= state_nxt;

            case (state)
                ST_IDLE: begin
                    if (!clear_pending && |bus.req)
                        bus.gnt <= arb_gnt;
                end
                ST_GRANT: begin
                    if (g_release) begin
                        bus.gnt <= '0;
                        ptr     <= PTR_W'(rr_next(int'(g_idx), N_CLIENTS));
                    end
                end
                ST_CLEAR: begin
                    if (cx == X_W'(SCREEN_W - 1)) begin
                        cx <= '0;
                        cy <= (cy == Y_W'(SCREEN_H - 1)) ? '0 : cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: ;
            endcase

            // Pending is consumed on entry to CLEAR; requests during CLEAR are dropped
            if (state == ST_IDLE && clear_pending)
                clear_pending <= 1'b0;
            else if (clear_req && state != ST_CLEAR)
                clear_pending <= 1'b1;

            // Busy drops together with plot on the first IDLE cycle after the sweep
            if (clear_req && state != ST_CLEAR)
                clear_busy <= 1'b1;
            else if (state == ST_IDLE && !clear_pending)
                clear_busy <= 1'b0;
        end
    end

    // Registered adapter outputs; coordinates hold while IDLE
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    plot   <= 1'b1;
                    x      <= cx;
                    y      <= cy;
                    colour <= CLEAR_COLOUR;
                end
                ST_GRANT: begin
                    plot   <= g_plot;
                    x      <= g_x;
                    y      <= g_y;
                    colour <= g_colour;
                end
                default: plot <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, single client pass-through,
// round-robin alternation, full clear sweep, deferred clear, ungranted strobe.
module tb_vga_plot_arbiter;

    localparam int N  = 2;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic          CLOCK_50  = 1'b0;
    logic          resetn    = 1'b0;
    logic          clear_req = 1'b0;
    logic          clear_busy;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          plot;

    int n_vec = 0;
    int n_bad = 0;

    vga_plot_arbiter_if #(.N_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) bus ();

    vga_plot_arbiter #(.N_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOUR_W(CW)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .bus        (bus),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_client(input int g, input logic p, input logic [XW-1:0] xv,
                                input logic [YW-1:0] yv, input logic [CW-1:0] cv);
        bus.plot_in[g]           = p;
        bus.x_in[g*XW +: XW]     = xv;
        bus.y_in[g*YW +: YW]     = yv;
        bus.colour_in[g*CW +: CW] = cv;
    endtask

    // Follow one clear sweep from its first plot to the cycle plot falls
    task automatic run_sweep(input string tag, input bit poke);
        int cnt = 0, bad_ord = 0, bad_col = 0, bad_busy = 0, bad_gnt = 0;
        int ex = 0, ey = 0, lx = -1, ly = -1;
        bit started = 0, ended = 0;
        for (int c = 0; c < 20000 && !ended; c++) begin
            step();
            if (plot) begin
                started = 1;
                if (int'(x) != ex || int'(y) != ey) bad_ord++;
                if (colour != 3'b000) bad_col++;
                if (!clear_busy) bad_busy++;
                if (bus.gnt != '0) bad_gnt++;
                lx = int'(x);
                ly = int'(y);
                cnt++;
                ex++;
                if (ex == 160) begin
                    ex = 0;
                    ey++;
                end
                clear_req = (poke && cnt == 100);
            end else if (started) begin
                ended = 1;
                check_vec({tag, "_busy_fall"}, 32'(clear_busy), 32'd0);
            end
        end
        clear_req = 1'b0;
        check_vec({tag, "_ended"},    32'(ended),    32'd1);
        check_vec({tag, "_count"},    32'(cnt),      32'd19200);
        check_vec({tag, "_last_x"},   32'(lx),       32'd159);
        check_vec({tag, "_last_y"},   32'(ly),       32'd119);
        check_vec({tag, "_order"},    32'(bad_ord),  32'd0);
        check_vec({tag, "_colour"},   32'(bad_col),  32'd0);
        check_vec({tag, "_busy_hi"},  32'(bad_busy), 32'd0);
        check_vec({tag, "_no_gnt"},   32'(bad_gnt),  32'd0);
    endtask

    initial begin
        bit found;
        bus.req       = '0;
        bus.done      = '0;
        bus.plot_in   = '0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;

        // Reset values
        repeat (3) step();
        check_vec("rst_gnt",    32'(bus.gnt),    32'd0);
        check_vec("rst_plot",   32'(plot),       32'd0);
        check_vec("rst_x",      32'(x),          32'd0);
        check_vec("rst_y",      32'(y),          32'd0);
        check_vec("rst_colour", 32'(colour),     32'd0);
        check_vec("rst_busy",   32'(clear_busy), 32'd0);
        resetn = 1'b1;
        step();

        // T1: reset in the middle of a sweep at (37,5)
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_vec("t1_busy_set", 32'(clear_busy), 32'd1);
        found = 0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (plot && x == 8'd37 && y == 7'd5) begin
                found = 1;
                break;
            end
        end
        check_vec("t1_reached_37_5", 32'(found), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check_vec("t1_gnt",  32'(bus.gnt),    32'd0);
        check_vec("t1_plot", 32'(plot),       32'd0);
        check_vec("t1_x",    32'(x),          32'd0);
        check_vec("t1_y",    32'(y),          32'd0);
        check_vec("t1_busy", 32'(clear_busy), 32'd0);
        step();
        resetn = 1'b1;
        repeat (3) step();
        check_vec("t1_no_resume_plot", 32'(plot),       32'd0);
        check_vec("t1_no_resume_busy", 32'(clear_busy), 32'd0);

        // T2: single client pass-through; T6: ungranted strobe ignored
        bus.req = 2'b01;
        step();
        check_vec("t2_gnt", 32'(bus.gnt), 32'd1);
        drive_client(1, 1'b1, 8'd200, 7'd100, 3'd7);
        step();
        check_vec("t6_ungranted", 32'(plot), 32'd0);
        for (int i = 0; i < 30; i++) begin
            drive_client(0, 1'b1, 8'(30 + i), 7'd30, 3'(i % 8));
            bus.done[0] = (i == 29);
            step();
            check_vec("t2_plot",   32'(plot),   32'd1);
            check_vec("t2_x",      32'(x),      32'(30 + i));
            check_vec("t2_y",      32'(y),      32'd30);
            check_vec("t2_colour", 32'(colour), 32'(i % 8));
        end
        check_vec("t2_gnt_release", 32'(bus.gnt), 32'd0);
        drive_client(0, 1'b0, 8'd0, 7'd0, 3'd0);
        drive_client(1, 1'b0, 8'd0, 7'd0, 3'd0);
        bus.done = '0;
        bus.req  = '0;
        step();
        check_vec("t2_plot_idle", 32'(plot), 32'd0);

        // T3: round-robin with both requesting; pointer is 1 after T2
        bus.req = 2'b11;
        step();
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k % 2 == 0) ? 1 : 0;
            check_vec("t3_gnt", 32'(bus.gnt), 32'(1 << g));
            for (int p = 0; p < 4; p++) begin
                drive_client(g, 1'b1, 8'(100 + k*4 + p), 7'(10 + k), 3'd3);
                bus.done = (p == 3) ? 2'(1 << g) : 2'b00;
                step();
                check_vec("t3_plot", 32'(plot), 32'd1);
                check_vec("t3_x",    32'(x),    32'(100 + k*4 + p));
            end
            drive_client(g, 1'b0, 8'd0, 7'd0, 3'd0);
            bus.done = '0;
            check_vec("t3_gnt_release", 32'(bus.gnt), 32'd0);
            if (k == 3) bus.req = '0;
            step();
        end
        check_vec("t3_gnt_final", 32'(bus.gnt), 32'd0);

        // T4: full sweep from IDLE, with a clear_req poked mid-sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_vec("t4_busy_set", 32'(clear_busy), 32'd1);
        run_sweep("t4", 1'b1);
        repeat (3) step();
        check_vec("t4_no_restart_plot", 32'(plot),       32'd0);
        check_vec("t4_no_restart_busy", 32'(clear_busy), 32'd0);

        // T5: clear deferred behind client 1; client 0 waits for the sweep
        bus.req = 2'b10;
        step();
        check_vec("t5_gnt1", 32'(bus.gnt), 32'd2);
        bus.req = 2'b11;
        for (int p = 0; p < 6; p++) begin
            drive_client(1, 1'b1, 8'(50 + p), 7'd60, 3'd5);
            bus.done  = (p == 5) ? 2'b10 : 2'b00;
            clear_req = (p == 2);
            step();
            check_vec("t5_plot", 32'(plot), 32'd1);
            check_vec("t5_x",    32'(x),    32'(50 + p));
            if (p >= 2) check_vec("t5_busy", 32'(clear_busy), 32'd1);
        end
        drive_client(1, 1'b0, 8'd0, 7'd0, 3'd0);
        bus.done  = '0;
        clear_req = 1'b0;
        bus.req   = 2'b01;
        check_vec("t5_gnt_release", 32'(bus.gnt), 32'd0);
        run_sweep("t5", 1'b0);
        check_vec("t5_gnt0_after", 32'(bus.gnt), 32'd1);
        bus.done = 2'b01;
        step();
        check_vec("t5_gnt0_release", 32'(bus.gnt), 32'd0);
        bus.done = '0;
        bus.req  = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
